// File: rtl/upe_tripleadd_seq_if.sv
// rtl/upe_tripleadd_seq_if.sv - operand/result bundle for the sliced triple adder
interface upe_tripleadd_seq_if #(
  parameter int NWORDS = 4
);
  localparam int W = 32 * NWORDS;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] c;
  logic         carryin1;
  logic         carryin2;
  logic         busy;
  logic         done;
  logic [W-1:0] out;
  logic         carryout1;
  logic         carryout2;

  modport master (
    output start, a, b, c, carryin1, carryin2,
    input  busy, done, out, carryout1, carryout2
  );

  modport slave (
    input  start, a, b, c, carryin1, carryin2,
    output busy, done, out, carryout1, carryout2
  );
endinterface

// File: rtl/upe_tripleadd_seq.sv
// rtl/upe_tripleadd_seq.sv - (a+b+ci1)+c+ci2 over W bits, one 32-bit slice per cycle
module upe_tripleadd32 (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [31:0] i_c,
  input  logic        i_ci1,
  input  logic        i_ci2,
  output logic [31:0] o_sum,
  output logic        o_co1,
  output logic        o_co2
);
  logic [32:0] w_s1;
  logic [32:0] w_s2;

  assign w_s1  = {1'b0, i_a} + {1'b0, i_b} + {32'd0, i_ci1};
  assign w_s2  = {1'b0, w_s1[31:0]} + {1'b0, i_c} + {32'd0, i_ci2};
  assign o_sum = w_s2[31:0];
  assign o_co1 = w_s1[32];
  assign o_co2 = w_s2[32];
endmodule

module upe_tripleadd_seq #(
  parameter int NWORDS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  upe_tripleadd_seq_if.slave   bus
);
  localparam int W  = 32 * NWORDS;
  localparam int KW = $clog2(NWORDS + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t       r_state;
  state_t       w_next_state;
  logic         w_busy;
  logic         w_done;
  logic         w_accept;
  logic         w_last;

  logic [KW-1:0] r_k;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_c;
  logic          r_cy1;
  logic          r_cy2;
  logic [W-1:0]  r_out;
  logic          r_co1;
  logic          r_co2;

  logic [31:0]   w_sum;
  logic          w_co1;
  logic          w_co2;

  // Operand registers shift right each slice, so the adder always reads bits [31:0].
  upe_tripleadd32 u_slice (
    .i_a   (r_a[31:0]),
    .i_b   (r_b[31:0]),
    .i_c   (r_c[31:0]),
    .i_ci1 (r_cy1),
    .i_ci2 (r_cy2),
    .o_sum (w_sum),
    .o_co1 (w_co1),
    .o_co2 (w_co2)
  );

  assign w_last   = (r_k == KW'(NWORDS - 1));
  assign w_accept = bus.start && (r_state == S_IDLE || r_state == S_DONE);

  always_comb begin
    w_next_state = r_state;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_next_state = S_RUN;
      end
      S_RUN: begin
        w_busy = 1'b1;
        if (w_last) w_next_state = S_DONE;
      end
      S_DONE: begin
        w_done       = 1'b1;
        w_next_state = bus.start ? S_RUN : S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_cy1   <= 1'b0;
      r_cy2   <= 1'b0;
      r_out   <= '0;
      r_co1   <= 1'b0;
      r_co2   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_a   <= bus.a;
        r_b   <= bus.b;
        r_c   <= bus.c;
        r_cy1 <= bus.carryin1;
        r_cy2 <= bus.carryin2;
        r_k   <= '0;
      end else if (r_state == S_RUN) begin
        for (int i = 0; i < NWORDS; i++) begin
          if (r_k == KW'(i)) r_out[32*i +: 32] <= w_sum;
        end
        r_a   <= r_a >> 32;
        r_b   <= r_b >> 32;
        r_c   <= r_c >> 32;
        r_cy1 <= w_co1;
        r_cy2 <= w_co2;
        if (w_last) begin
          r_co1 <= w_co1;
          r_co2 <= w_co2;
        end else begin
          r_k <= r_k + KW'(1);
        end
      end
    end
  end

  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.out       = r_out;
  assign bus.carryout1 = r_co1;
  assign bus.carryout2 = r_co2;
endmodule

// File: tb/tb_upe_tripleadd_seq.sv
// tb/tb_upe_tripleadd_seq.sv - scoreboard bench for upe_tripleadd_seq
module tb_upe_tripleadd_seq;
  localparam int NWORDS = 4;
  localparam int W      = 32 * NWORDS;

  typedef struct packed {
    logic [W-1:0] out;
    logic         co1;
    logic         co2;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  upe_tripleadd_seq_if #(.NWORDS(NWORDS)) bus_if ();
  upe_tripleadd_seq #(.NWORDS(NWORDS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  localparam logic [W-1:0] ONES = {W{1'b1}};

  function automatic exp_t model(input logic [W-1:0] a, b, c, input logic ci1, ci2);
    logic [W:0] s1;
    logic [W:0] s2;
    exp_t       e;
    s1    = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci1};
    s2    = {1'b0, s1[W-1:0]} + {1'b0, c} + {{W{1'b0}}, ci2};
    e.out = s2[W-1:0];
    e.co1 = s1[W];
    e.co2 = s2[W];
    return e;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  always @(negedge clk) begin
    if (bus_if.done === 1'b1) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: got done=1 required no pending operation");
      end else begin
        mon_e = sb_q.pop_front();
        if (bus_if.out !== mon_e.out || bus_if.carryout1 !== mon_e.co1 ||
            bus_if.carryout2 !== mon_e.co2) begin
          n_fail++;
          $display("FAIL result: got out=%h co1=%b co2=%b required out=%h co1=%b co2=%b",
                   bus_if.out, bus_if.carryout1, bus_if.carryout2,
                   mon_e.out, mon_e.co1, mon_e.co2);
        end
      end
    end
  end

  task automatic set_ops(input logic [W-1:0] a, b, c, input logic ci1, ci2);
    bus_if.a        = a;
    bus_if.b        = b;
    bus_if.c        = c;
    bus_if.carryin1 = ci1;
    bus_if.carryin2 = ci2;
  endtask

  task automatic do_op(input logic [W-1:0] a, b, c, input logic ci1, ci2,
                       input exp_t e, input bit tog);
    @(negedge clk);
    set_ops(a, b, c, ci1, ci2);
    bus_if.start = 1'b1;
    sb_q.push_back(e);
    for (int k = 1; k <= NWORDS; k++) begin
      @(negedge clk);
      chk("busy_run", W'(bus_if.busy), W'(1));
      chk("done_run", W'(bus_if.done), W'(0));
      if (tog) begin
        set_ops(rnd(), rnd(), rnd(), 1'($urandom), 1'($urandom));
        bus_if.start = (k < NWORDS) ? 1'($urandom) : 1'b0;
      end else begin
        bus_if.start = 1'b0;
      end
    end
    @(negedge clk);
    chk("done_pulse", W'(bus_if.done), W'(1));
    chk("busy_done", W'(bus_if.busy), W'(0));
  endtask

  initial begin
    exp_t e;
    exp_t ops_e[4];
    logic [W-1:0] ops_a[4];
    logic [W-1:0] ops_b[4];
    logic [W-1:0] ops_c[4];
    logic [1:0]   ops_ci[4];
    logic [W-1:0] ra, rb, rc;
    logic         r1, r2;

    reset = 1'b1;
    bus_if.start = 1'b0;
    set_ops('0, '0, '0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_busy", W'(bus_if.busy), W'(0));
    chk("rst_done", W'(bus_if.done), W'(0));
    chk("rst_out", bus_if.out, '0);
    chk("rst_co1", W'(bus_if.carryout1), W'(0));
    chk("rst_co2", W'(bus_if.carryout2), W'(0));
    reset = 1'b0;

    // Directed vectors with hand-computed results.
    do_op('0, '0, '0, 1'b0, 1'b0, '{out: '0, co1: 1'b0, co2: 1'b0}, 1'b0);
    do_op(ONES, '0, '0, 1'b1, 1'b0, '{out: '0, co1: 1'b1, co2: 1'b0}, 1'b0);
    do_op(ONES, W'(1), ONES, 1'b0, 1'b1, '{out: '0, co1: 1'b1, co2: 1'b1}, 1'b0);
    do_op(W'(5), W'(7), W'(9), 1'b1, 1'b1, '{out: W'(23), co1: 1'b0, co2: 1'b0}, 1'b1);
    @(negedge clk);
    chk("hold_out", bus_if.out, W'(23));
    do_op(ONES, ONES, '0, 1'b0, 1'b0, '{out: {{(W-1){1'b1}}, 1'b0}, co1: 1'b1, co2: 1'b0}, 1'b0);
    do_op(W'(64'h1_FFFF_FFFF), W'(1), '0, 1'b0, 1'b0,
          '{out: W'(64'h2_0000_0000), co1: 1'b0, co2: 1'b0}, 1'b1);

    // start held high: accepts only in IDLE/DONE, done every NWORDS+1 cycles.
    ops_a[0] = W'(1);   ops_b[0] = W'(2); ops_c[0] = W'(3);  ops_ci[0] = 2'b00;
    ops_e[0] = '{out: W'(6), co1: 1'b0, co2: 1'b0};
    ops_a[1] = ONES;    ops_b[1] = W'(1); ops_c[1] = '0;     ops_ci[1] = 2'b00;
    ops_e[1] = '{out: '0, co1: 1'b1, co2: 1'b0};
    ops_a[2] = W'(10);  ops_b[2] = W'(20); ops_c[2] = ONES;  ops_ci[2] = 2'b01;
    ops_e[2] = '{out: W'(30), co1: 1'b0, co2: 1'b1};
    ops_a[3] = W'(100); ops_b[3] = '0;    ops_c[3] = '0;     ops_ci[3] = 2'b11;
    ops_e[3] = '{out: W'(102), co1: 1'b0, co2: 1'b0};
    @(negedge clk);
    set_ops(ops_a[0], ops_b[0], ops_c[0], ops_ci[0][1], ops_ci[0][0]);
    bus_if.start = 1'b1;
    sb_q.push_back(ops_e[0]);
    for (int cyc = 1; cyc <= 4 * (NWORDS + 1); cyc++) begin
      @(negedge clk);
      chk("b2b_busy", W'(bus_if.busy), W'((cyc % (NWORDS + 1)) != 0));
      chk("b2b_done", W'(bus_if.done), W'((cyc % (NWORDS + 1)) == 0));
      if (cyc % (NWORDS + 1) == 0) begin
        if (cyc / (NWORDS + 1) < 4) begin
          set_ops(ops_a[cyc/(NWORDS+1)], ops_b[cyc/(NWORDS+1)], ops_c[cyc/(NWORDS+1)],
                  ops_ci[cyc/(NWORDS+1)][1], ops_ci[cyc/(NWORDS+1)][0]);
          sb_q.push_back(ops_e[cyc/(NWORDS+1)]);
        end else begin
          bus_if.start = 1'b0;
        end
      end else begin
        set_ops(rnd(), rnd(), rnd(), 1'($urandom), 1'($urandom));
      end
    end

    // Reset in the third RUN cycle aborts without a done pulse.
    @(negedge clk);
    set_ops(ONES, ONES, ONES, 1'b1, 1'b1);
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", W'(bus_if.busy), W'(0));
    chk("abort_done", W'(bus_if.done), W'(0));
    chk("abort_out", bus_if.out, '0);
    chk("abort_co1", W'(bus_if.carryout1), W'(0));
    reset = 1'b0;
    repeat (NWORDS + 2) begin
      @(negedge clk);
      chk("abort_no_done", W'(bus_if.done), W'(0));
    end
    do_op(W'(3), W'(4), W'(5), 1'b0, 1'b1, '{out: W'(13), co1: 1'b0, co2: 1'b0}, 1'b0);

    // start coincident with reset is dropped.
    @(negedge clk);
    reset = 1'b1;
    bus_if.start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus_if.start = 1'b0;
    chk("rst_start_drop", W'(bus_if.busy), W'(0));
    @(negedge clk);
    chk("rst_start_drop2", W'(bus_if.busy), W'(0));

    for (int i = 0; i < 10000; i++) begin
      ra = rnd(); rb = rnd(); rc = rnd();
      if (i % 8 == 0) ra = ONES;
      r1 = 1'($urandom); r2 = 1'($urandom);
      e  = model(ra, rb, rc, r1, r2);
      do_op(ra, rb, rc, r1, r2, e, 1'b1);
    end

    @(negedge clk);
    chk("queue_drained", W'(sb_q.size()), W'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
